// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: issues one divide to basediv, holds its inputs, returns result/tag with watchdog and flush.
// Optional macro DIVCTL_DIVZERO_FAST_EN answers y==0 requests directly without a divider transaction.
module div_issue_ctrl #(
  parameter int TAG_W   = 5,
  parameter int TIMEOUT = 34
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_signed,
  input  logic [31:0]      req_x,
  input  logic [31:0]      req_y,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_s,
  output logic [31:0]      resp_r,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_err,
  output logic             div_in_valid,
  input  logic             div_in_ready,
  output logic             div_signed,
  output logic [31:0]      div_x,
  output logic [31:0]      div_y,
  input  logic [31:0]      div_s,
  input  logic [31:0]      div_r,
  input  logic             div_out_valid
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t           state_q, state_d;
  logic             issued_q, issued_d, signed_q, signed_d, err_q, err_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [31:0]      x_q, x_d, y_q, y_d, s_q, s_d, r_q, r_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             accept, done, expired;
  assign req_ready    = (state_q == IDLE) & ~flush & ~reset;
  assign accept       = req_valid & req_ready;
  assign div_in_valid = (state_q == BUSY) & ~reset;
  assign resp_valid   = state_q == RESP;
  assign div_signed   = signed_q;
  assign div_x        = x_q;
  assign div_y        = y_q;
  assign resp_s       = s_q;
  assign resp_r       = r_q;
  assign resp_tag     = tag_q;
  assign resp_err     = err_q;
  // out_valid only counts once the divider has taken the operands; it beats the watchdog
  assign done    = issued_q & div_out_valid;
  assign expired = issued_q & (cnt_q == CW'(TIMEOUT - 1)) & ~div_out_valid;
  always_comb begin
    state_d  = state_q;
    issued_d = issued_q;
    cnt_d    = cnt_q;
    signed_d = signed_q;
    x_d      = x_q;
    y_d      = y_q;
    tag_d    = tag_q;
    s_d      = s_q;
    r_d      = r_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: if (accept) begin
        signed_d = req_signed;
        x_d      = req_x;
        y_d      = req_y;
        tag_d    = req_tag;
        issued_d = 1'b0;
        cnt_d    = '0;
`ifdef DIVCTL_DIVZERO_FAST_EN
        if (req_y == 32'd0) begin
          state_d = RESP;
          s_d     = 32'hFFFF_FFFF;
          r_d     = req_x;
          err_d   = 1'b0;
        end else begin
          state_d = BUSY;
        end
`else
        state_d = BUSY;
`endif
      end
      BUSY: begin
        issued_d = issued_q | div_in_ready;
        cnt_d    = issued_q ? cnt_q + CW'(1) : '0;
        state_d  = (done | expired) ? RESP : BUSY;
        s_d      = done ? div_s : expired ? 32'd0 : s_q;
        r_d      = done ? div_r : expired ? 32'd0 : r_q;
        err_d    = done ? 1'b0 : expired ? 1'b1 : err_q;
      end
      RESP: state_d = resp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d  = IDLE;
      issued_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      issued_q <= 1'b0;
      cnt_q    <= '0;
      signed_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      tag_q    <= '0;
      s_q      <= '0;
      r_q      <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      issued_q <= issued_d;
      cnt_q    <= cnt_d;
      signed_q <= signed_d;
      x_q      <= x_d;
      y_q      <= y_d;
      tag_q    <= tag_d;
      s_q      <= s_d;
      r_q      <= r_d;
      err_q    <= err_d;
    end
  end
endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl: directed bench for div_issue_ctrl, divider side driven by hand.
module tb_div_issue_ctrl;
  logic        clk = 0, reset, flush, req_valid, req_ready, req_signed;
  logic [31:0] req_x, req_y, resp_s, resp_r, div_x, div_y, div_s, div_r;
  logic [4:0]  req_tag, resp_tag;
  logic        resp_valid, resp_ready, resp_err, div_in_valid, div_in_ready;
  logic        div_signed, div_out_valid;
  int          n_cmp = 0, n_err = 0, hi;
  div_issue_ctrl dut (
    .clk(clk), .reset(reset), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
    .req_signed(req_signed), .req_x(req_x), .req_y(req_y), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_s(resp_s), .resp_r(resp_r),
    .resp_tag(resp_tag), .resp_err(resp_err), .div_in_valid(div_in_valid),
    .div_in_ready(div_in_ready), .div_signed(div_signed), .div_x(div_x), .div_y(div_y),
    .div_s(div_s), .div_r(div_r), .div_out_valid(div_out_valid)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic request(input logic sg, input logic [31:0] x, input logic [31:0] y, input logic [4:0] t);
    req_valid = 1; req_signed = sg; req_x = x; req_y = y; req_tag = t;
    tick();
    req_valid = 0;
  endtask
  initial begin
    reset = 1; flush = 0; req_valid = 0; req_signed = 0; req_x = 0; req_y = 0; req_tag = 0;
    resp_ready = 0; div_in_ready = 0; div_s = 0; div_r = 0; div_out_valid = 0;
    tick(); tick();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_in_valid", div_in_valid, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_resp_s", resp_s, 0);
    chk("rst_div_x", div_x, 0);
    reset = 0; #1;
    chk("idle_req_ready", req_ready, 1);
    // 1: unsigned 100/7, divider takes 33 in_valid cycles
    request(0, 100, 7, 5);
    chk("t1_in_valid", div_in_valid, 1);
    chk("t1_div_x", div_x, 100);
    chk("t1_div_y", div_y, 7);
    chk("t1_div_signed", div_signed, 0);
    chk("t1_req_ready", req_ready, 0);
    hi = int'(div_in_valid);
    div_in_ready = 1; tick(); div_in_ready = 0;
    repeat (31) begin hi += int'(div_in_valid); tick(); end
    div_out_valid = 1; div_s = 14; div_r = 2; #1;
    hi += int'(div_in_valid);
    chk("t1_no_resp_yet", resp_valid, 0);
    tick(); div_out_valid = 0; div_s = 0; div_r = 0;
    chk("t1_in_valid_cycles", hi, 33);
    chk("t1_resp_valid", resp_valid, 1);
    chk("t1_resp_s", resp_s, 14);
    chk("t1_resp_r", resp_r, 2);
    chk("t1_resp_tag", resp_tag, 5);
    chk("t1_resp_err", resp_err, 0);
    chk("t1_in_valid_resp", div_in_valid, 0);
    // 3: backpressure with a pending second request
    req_valid = 1; req_signed = 1; req_x = 32'hFFFF_FFF9; req_y = 2; req_tag = 12;
    repeat (5) begin
      tick();
      chk("t3_hold_s", resp_s, 14);
      chk("t3_hold_valid", resp_valid, 1);
      chk("t3_req_ready", req_ready, 0);
    end
    resp_ready = 1; tick(); resp_ready = 0;
    chk("t3_after_hs_valid", resp_valid, 0);
    chk("t3_after_hs_ready", req_ready, 1);
    chk("t3_not_yet_issued", div_in_valid, 0);
    tick(); req_valid = 0;
    // 2: signed -7/2
    chk("t2_in_valid", div_in_valid, 1);
    chk("t2_div_signed", div_signed, 1);
    chk("t2_div_x", div_x, 32'hFFFF_FFF9);
    div_in_ready = 1; tick(); div_in_ready = 0;
    repeat (4) tick();
    chk("t2_signed_held", div_signed, 1);
    chk("t2_y_held", div_y, 2);
    div_out_valid = 1; div_s = 32'hFFFF_FFFD; div_r = 32'hFFFF_FFFF;
    tick(); div_out_valid = 0;
    chk("t2_resp_s", resp_s, 32'hFFFF_FFFD);
    chk("t2_resp_r", resp_r, 32'hFFFF_FFFF);
    chk("t2_resp_tag", resp_tag, 12);
    resp_ready = 1; tick(); resp_ready = 0;
    // 4: watchdog, 34 cycles after divider acceptance
    request(0, 9, 3, 7);
    div_in_ready = 1; tick(); div_in_ready = 0;
    repeat (33) tick();
    chk("t4_in_valid_last", div_in_valid, 1);
    chk("t4_no_resp_early", resp_valid, 0);
    tick();
    chk("t4_resp_valid", resp_valid, 1);
    chk("t4_resp_err", resp_err, 1);
    chk("t4_resp_s", resp_s, 0);
    chk("t4_resp_r", resp_r, 0);
    chk("t4_resp_tag", resp_tag, 7);
    chk("t4_in_valid_resp", div_in_valid, 0);
    resp_ready = 1; tick(); resp_ready = 0;
    // 5: flush on 10th busy cycle, late out_valid ignored
    request(0, 50, 5, 9);
    div_in_ready = 1; tick(); div_in_ready = 0;
    repeat (8) tick();
    flush = 1; #1;
    chk("t5_flush_req_ready", req_ready, 0);
    tick(); flush = 0; #1;
    chk("t5_in_valid", div_in_valid, 0);
    chk("t5_resp_valid", resp_valid, 0);
    chk("t5_idle_ready", req_ready, 1);
    tick(); tick();
    div_out_valid = 1; div_s = 123; tick(); div_out_valid = 0;
    chk("t5_late_ignored", resp_valid, 0);
    chk("t5_late_in_valid", div_in_valid, 0);
    request(0, 20, 6, 3);
    div_in_ready = 1; tick(); div_in_ready = 0;
    tick();
    div_out_valid = 1; div_s = 3; div_r = 2; tick(); div_out_valid = 0;
    chk("t5_new_s", resp_s, 3);
    chk("t5_new_r", resp_r, 2);
    chk("t5_new_tag", resp_tag, 3);
    chk("t5_new_err", resp_err, 0);
    flush = 1; resp_ready = 1; tick(); flush = 0; resp_ready = 0;
    chk("t5_flush_resp", resp_valid, 0);
    // 6: divide by zero
    request(0, 5, 0, 1);
`ifdef DIVCTL_DIVZERO_FAST_EN
    chk("t6_resp_valid", resp_valid, 1);
    chk("t6_resp_s", resp_s, 32'hFFFF_FFFF);
    chk("t6_resp_r", resp_r, 5);
    chk("t6_resp_err", resp_err, 0);
    chk("t6_in_valid", div_in_valid, 0);
`else
    chk("t6_in_valid", div_in_valid, 1);
    chk("t6_div_y", div_y, 0);
    chk("t6_resp_valid", resp_valid, 0);
`endif
    // reset mid-op drops everything, in_valid low within the reset cycle
    reset = 1; #1;
    chk("rst_mid_in_valid", div_in_valid, 0);
    chk("rst_mid_req_ready", req_ready, 0);
    tick(); reset = 0; #1;
    chk("rst_mid_resp_valid", resp_valid, 0);
    chk("rst_mid_resp_s", resp_s, 0);
    chk("rst_mid_ready", req_ready, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
